// File: rtl/sym_pkg.sv
// Shared types and limits for the oversampling symbol decoder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sym_pkg;

   localparam int SYM_RUN_W      = 4;
   localparam int SYM_GLITCH_W   = 8;
   localparam int SYM_STABLE_MAX = 15;

   // 2'b11 is deliberately left out; the FSM maps it back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      EMIT = 2'b10
   } sym_state_t;

endpackage

// File: rtl/sym_run_counter.sv
// Run-length counter for the decoder: clear / load-to-1 / increment.
// Latency: run updates on the edge after the command; done is combinational from run.
// Backpressure: none; the count only moves when the FSM commands it.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clr         - force run to 0 (highest priority after reset)
//   load        - start a new run, run = 1
//   inc         - extend the current run by one sample
//   run         - current sample count
//   done        - the next matching sample completes a symbol (run+1 == STABLE_CYCLES)
module sym_run_counter
   import sym_pkg::*;
#(
   parameter int STABLE_CYCLES = 3   // legal range 2..SYM_STABLE_MAX
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 load,
   input  logic                 inc,
   output logic [SYM_RUN_W-1:0] run,
   output logic                 done
);

   // One extra bit so run+1 cannot wrap before the compare.
   localparam logic [SYM_RUN_W:0] TARGET = (SYM_RUN_W+1)'(STABLE_CYCLES);

   logic [SYM_RUN_W:0] run_plus1;

   assign run_plus1 = {1'b0, run} + (SYM_RUN_W+1)'(1);
   assign done      = (run_plus1 == TARGET);

   always_ff @(posedge clk) begin
      if (reset) begin
         run <= '0;
      end else if (clr) begin
         run <= '0;
      end else if (load) begin
         run <= SYM_RUN_W'(1);
      end else if (inc) begin
         run <= run + SYM_RUN_W'(1);
      end
   end

endmodule

// File: rtl/sym_oversample_decoder.sv
// Oversampling symbol decoder: one ONE/ZERO pulse per run of STABLE_CYCLES equal samples.
// Latency: pulse is registered on the same edge that takes the completing sample, high one cycle.
// Backpressure: none; samples are taken on din_en strobes only, gaps hold the run.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset (priority over all inputs)
//   din         - raw serial line level
//   din_en      - sample strobe
//   ONE, ZERO   - registered one-cycle symbol pulses, mutually exclusive
//   state       - current FSM state for debug
//   glitch_cnt  - saturating count of broken runs (only with SYM_GLITCH_COUNT_EN defined)
module sym_oversample_decoder
   import sym_pkg::*;
#(
   parameter int STABLE_CYCLES = 3   // legal range 2..SYM_STABLE_MAX
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    din,
   input  logic                    din_en,
   output logic                    ONE,
   output logic                    ZERO,
   output logic [1:0]              state
`ifdef SYM_GLITCH_COUNT_EN
   ,
   output logic [SYM_GLITCH_W-1:0] glitch_cnt
`endif
);

   sym_state_t           state_q, state_d;
   logic                 cand_q, cand_d;
   logic                 one_d, zero_d;
   logic                 cnt_clr, cnt_load, cnt_inc;
   logic [SYM_RUN_W-1:0] run;
   logic                 run_done;

   sym_run_counter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_run (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .load  (cnt_load),
      .inc   (cnt_inc),
      .run   (run),
      .done  (run_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cand_q  <= 1'b0;
         ONE     <= 1'b0;
         ZERO    <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         ONE     <= one_d;
         ZERO    <= zero_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      one_d    = 1'b0;
      zero_d   = 1'b0;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;

      case (state_q)
         IDLE: begin
            if (din_en) begin
               state_d  = ACC;
               cand_d   = din;
               cnt_load = 1'b1;
            end
         end

         ACC: begin
            if (din_en) begin
               if (din == cand_q) begin
                  if (run_done) begin
                     state_d = EMIT;
                     one_d   = cand_q;
                     zero_d  = ~cand_q;
                     cnt_clr = 1'b1;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  // Level changed mid-run: drop the partial run, restart on the new level.
                  cand_d   = din;
                  cnt_load = 1'b1;
               end
            end
         end

         EMIT: begin
            // A sample arriving during EMIT always opens a fresh run, so a long
            // steady level produces one pulse per STABLE_CYCLES strobes.
            if (din_en) begin
               state_d  = ACC;
               cand_d   = din;
               cnt_load = 1'b1;
            end else begin
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   assign state = state_q;

`ifdef SYM_GLITCH_COUNT_EN
   logic glitch_evt;

   // Only a mismatch inside ACC counts; the IDLE->ACC start never does.
   assign glitch_evt = (state_q == ACC) && din_en && (din != cand_q) && (run != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         glitch_cnt <= '0;
      end else if (glitch_evt && (glitch_cnt != {SYM_GLITCH_W{1'b1}})) begin
         glitch_cnt <= glitch_cnt + SYM_GLITCH_W'(1);
      end
   end
`endif

endmodule
